// File: rtl/gshare_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus a 2-bit-counter PHT with speculative GHSR.
// Define GSHARE_HASH_EN for gshare indexing (PC ^ GHSR); otherwise the PHT is indexed by PC bits only.
module gshare_predictor #(
    parameter int unsigned GSHARE_GHSR_WIDTH = 8,
    parameter int unsigned BTB_ENTRIES       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_valid,
    input  logic [31:0]                  fetch_pc,
    output logic [31:0]                  next_pc,
    output logic                         pred_taken,
    output logic                         btb_hit,
    output logic [31:0]                  pred_target,
    output logic [GSHARE_GHSR_WIDTH-1:0] current_GHSR,
    input  logic                         upd_valid,
    input  logic [31:0]                  upd_pc,
    input  logic                         upd_is_jump,
    input  logic                         upd_taken,
    input  logic [31:0]                  upd_target,
    input  logic [GSHARE_GHSR_WIDTH-1:0] upd_ghsr,
    input  logic                         update_GHSR,
    input  logic [GSHARE_GHSR_WIDTH-1:0] GHSR_restore
);

    localparam int unsigned W     = GSHARE_GHSR_WIDTH;
    localparam int unsigned PHT_N = 1 << W;
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             jump;
    } btb_entry_t;

    btb_entry_t       btb [BTB_ENTRIES];
    logic [1:0]       pht [PHT_N];
    logic [W-1:0]     ghsr;

    logic [IDX_W-1:0] btb_idx;
    logic [TAG_W-1:0] btb_tag;
    logic [IDX_W-1:0] upd_btb_idx;
    logic [W-1:0]     pht_idx;
    logic [W-1:0]     upd_pht_idx;
    logic [1:0]       upd_ctr;
    btb_entry_t       entry;
    logic             hit_raw;
    logic             unused_ok;

    assign btb_idx     = fetch_pc[IDX_W+1:2];
    assign btb_tag     = fetch_pc[31:IDX_W+2];
    assign upd_btb_idx = upd_pc[IDX_W+1:2];

`ifdef GSHARE_HASH_EN
    assign pht_idx     = fetch_pc[W+1:2] ^ ghsr;
    assign upd_pht_idx = upd_pc[W+1:2] ^ upd_ghsr;
`else
    assign pht_idx     = fetch_pc[W+1:2];
    assign upd_pht_idx = upd_pc[W+1:2];
`endif

    // Bits that carry no information for this predictor.
    assign unused_ok = ^{upd_pc[1:0], GHSR_restore[W-1], upd_ghsr};

    // Zero-cycle lookup; reset masks the prediction so stale state never leaks out.
    assign entry        = btb[btb_idx];
    assign hit_raw      = entry.valid && (entry.tag == btb_tag);
    assign btb_hit      = hit_raw && !reset;
    assign pred_taken   = fetch_valid && btb_hit && (entry.jump || pht[pht_idx][1]);
    assign pred_target  = btb_hit ? entry.target : 32'd0;
    assign current_GHSR = reset ? W'(0) : ghsr;
    assign next_pc      = pred_taken ? pred_target : fetch_pc + 32'd4;

    assign upd_ctr = pht[upd_pht_idx];

    // Global history: mispredict repair overrides the speculative shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghsr <= '0;
        end else if (update_GHSR) begin
            ghsr <= {GHSR_restore[W-2:0], upd_taken};
        end else if (fetch_valid && btb_hit) begin
            ghsr <= {ghsr[W-2:0], pred_taken};
        end
    end

    // PHT training with saturating counters; jumps never train direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(PHT_N); i++) begin
                pht[i] <= 2'b01;
            end
        end else if (upd_valid && !upd_is_jump) begin
            if (upd_taken) begin
                if (upd_ctr != 2'b11) pht[upd_pht_idx] <= upd_ctr + 2'd1;
            end else begin
                if (upd_ctr != 2'b00) pht[upd_pht_idx] <= upd_ctr - 2'd1;
            end
        end
    end

    // BTB allocates or overwrites only on taken resolutions.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            btb[upd_btb_idx] <= '{valid:  1'b1,
                                  tag:    upd_pc[31:IDX_W+2],
                                  target: upd_target,
                                  jump:   upd_is_jump};
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed vector table, reset corner case, and randomized model comparison.
module tb_gshare_predictor;

`ifdef GSHARE_HASH_EN
    localparam bit HASH = 1'b1;
`else
    localparam bit HASH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic        btb_hit;
    logic [31:0] pred_target;
    logic [7:0]  current_GHSR;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_ghsr;
    logic        update_GHSR;
    logic [7:0]  GHSR_restore;

    int tests = 0;
    int fails = 0;

    gshare_predictor #(.GSHARE_GHSR_WIDTH(8), .BTB_ENTRIES(16)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .next_pc(next_pc), .pred_taken(pred_taken), .btb_hit(btb_hit),
        .pred_target(pred_target), .current_GHSR(current_GHSR),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghsr(upd_ghsr),
        .update_GHSR(update_GHSR), .GHSR_restore(GHSR_restore)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        uj;
        logic        ut;
        logic [31:0] utgt;
        logic [7:0]  ughsr;
        logic        ug;
        logic [7:0]  grest;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic [31:0] e_next;
        logic [7:0]  e_gh;
    } vec_t;

    vec_t vecs[$];

    // Reference model state.
    int          m_pht [256];
    bit          m_bv  [16];
    int unsigned m_btag[16];
    int unsigned m_btgt[16];
    bit          m_bj  [16];
    int unsigned m_gh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic row(input logic fv, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic uj, input logic ut,
                       input logic [31:0] utgt, input logic [7:0] ughsr,
                       input logic ug, input logic [7:0] grest,
                       input logic e_hit, input logic e_tk, input logic [31:0] e_tgt,
                       input logic [31:0] e_next, input logic [7:0] e_gh);
        vec_t v;
        v = '{fv, pc, uv, upc, uj, ut, utgt, ughsr, ug, grest, e_hit, e_tk, e_tgt, e_next, e_gh};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc,
                         input logic uv, input logic [31:0] upc, input logic uj, input logic ut,
                         input logic [31:0] utgt, input logic [7:0] ughsr,
                         input logic ug, input logic [7:0] grest);
        fetch_valid = fv;  fetch_pc = pc;
        upd_valid = uv;    upd_pc = upc;   upd_is_jump = uj;  upd_taken = ut;
        upd_target = utgt; upd_ghsr = ughsr;
        update_GHSR = ug;  GHSR_restore = grest;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 8'h0, 0, 8'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_gh = 0;
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0; m_bj[i] = 0;
        end
    endtask

    // Random PC drawn from a small window so BTB hits and tag conflicts are frequent.
    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 63) << 2));
    endfunction

    initial begin
        logic [31:0] pc, upc, exp_next, exp_tgt;
        logic        fv, uv, uj, ut, ug, exp_hit, exp_tk;
        logic [7:0]  ughsr, grest;
        logic [31:0] utgt;
        int unsigned bi, pi, ti;

        // Directed table: reset, training, conflicts, restore, saturation, JAL, PC wrap.
        row(1, 32'h100, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00,     0, 0, 0, 32'h104, 8'h00);
        row(1, 32'h100, 1, 32'h100, 0, 1, 32'h80, 8'h00, 0, 8'h00, 0, 0, 0, 32'h104, 8'h00);
        row(1, 32'h100, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00,     1, 1, 32'h80, 32'h80, 8'h00);
        row(1, 32'h140, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00,     0, 0, 0, 32'h144, 8'h01);
        row(1, 32'h100, 0, 0, 0, 1, 0, 8'h00, 1, 8'h5A,     1, HASH ? 1'b0 : 1'b1, 32'h80,
            HASH ? 32'h104 : 32'h80, 8'h01);
        row(0, 32'h0,   0, 0, 0, 0, 0, 8'h00, 0, 8'h00,     0, 0, 0, 32'h4, 8'hB5);
        for (int k = 0; k < 4; k++)
            row(0, 32'h0, 1, 32'h300, 0, 1, 32'h500, 8'hB5, 0, 8'h00, 0, 0, 0, 32'h4, 8'hB5);
        row(0, 32'h0,   1, 32'h300, 0, 0, 32'h500, 8'hB5, 0, 8'h00, 0, 0, 0, 32'h4, 8'hB5);
        row(1, 32'h300, 0, 0, 0, 1, 0, 8'h00, 1, 8'h5A,     1, 1, 32'h500, 32'h500, 8'hB5);
        row(0, 32'h0,   1, 32'h300, 0, 0, 32'h500, 8'hB5, 0, 8'h00, 0, 0, 0, 32'h4, 8'hB5);
        row(1, 32'h300, 0, 0, 0, 1, 0, 8'h00, 1, 8'h5A,     1, 0, 32'h500, 32'h304, 8'hB5);
        row(0, 32'h0,   1, 32'h40, 0, 0, 32'h0, 8'hB5, 0, 8'h00,   0, 0, 0, 32'h4, 8'hB5);
        row(0, 32'h0,   1, 32'h40, 1, 1, 32'h200, 8'hB5, 0, 8'h00, 0, 0, 0, 32'h4, 8'hB5);
        row(1, 32'h40,  0, 0, 0, 0, 0, 8'h00, 0, 8'h00,     1, 1, 32'h200, 32'h200, 8'hB5);
        row(1, 32'h300, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00,     0, 0, 0, 32'h304, 8'h6B);
        row(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 32'h0, 8'h6B);

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].uv, vecs[i].upc, vecs[i].uj, vecs[i].ut,
                  vecs[i].utgt, vecs[i].ughsr, vecs[i].ug, vecs[i].grest);
            #1;
            check($sformatf("row%0d btb_hit", i),      32'(btb_hit),      32'(vecs[i].e_hit));
            check($sformatf("row%0d pred_taken", i),   32'(pred_taken),   32'(vecs[i].e_tk));
            check($sformatf("row%0d pred_target", i),  pred_target,       vecs[i].e_tgt);
            check($sformatf("row%0d next_pc", i),      next_pc,           vecs[i].e_next);
            check($sformatf("row%0d current_GHSR", i), 32'(current_GHSR), 32'(vecs[i].e_gh));
            @(negedge clk);
        end

        // Mid-operation reset beats restore, training and a BTB-hit fetch.
        reset = 1'b1;
        drive(1, 32'h40, 1, 32'h40, 1, 1, 32'h300, 8'h00, 1, 8'h5A);
        #1;
        check("rst_during hit",  32'(btb_hit),      32'd0);
        check("rst_during tk",   32'(pred_taken),   32'd0);
        check("rst_during tgt",  pred_target,       32'd0);
        check("rst_during ghsr", 32'(current_GHSR), 32'd0);
        check("rst_during next", next_pc,           32'h44);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 32'h40, 0, 32'h0, 0, 0, 32'h0, 8'h00, 0, 8'h00);
        #1;
        check("rst_after hit",  32'(btb_hit),      32'd0);
        check("rst_after ghsr", 32'(current_GHSR), 32'd0);
        check("rst_after next", next_pc,           32'h44);
        @(negedge clk);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            fv    = 1'($urandom_range(0, 3) != 0);
            pc    = rand_pc();
            uv    = 1'($urandom_range(0, 1));
            upc   = rand_pc();
            uj    = 1'($urandom_range(0, 4) == 0);
            ut    = uj ? 1'b1 : 1'($urandom_range(0, 1));
            utgt  = 32'($urandom_range(0, 1023) << 2);
            ughsr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(m_gh);
            ug    = 1'($urandom_range(0, 7) == 0);
            grest = 8'($urandom);
            drive(fv, pc, uv, upc, uj, ut, utgt, ughsr, ug, grest);
            #1;

            bi       = (pc >> 2) % 16;
            pi       = ((pc >> 2) % 256) ^ (HASH ? m_gh : 0);
            exp_hit  = m_bv[bi] && (m_btag[bi] == (pc >> 6));
            exp_tk   = fv && exp_hit && (m_bj[bi] || m_pht[pi] >= 2);
            exp_tgt  = exp_hit ? 32'(m_btgt[bi]) : 32'd0;
            exp_next = exp_tk ? exp_tgt : pc + 32'd4;

            check($sformatf("rnd%0d btb_hit", n),      32'(btb_hit),      32'(exp_hit));
            check($sformatf("rnd%0d pred_taken", n),   32'(pred_taken),   32'(exp_tk));
            check($sformatf("rnd%0d pred_target", n),  pred_target,       exp_tgt);
            check($sformatf("rnd%0d next_pc", n),      next_pc,           exp_next);
            check($sformatf("rnd%0d current_GHSR", n), 32'(current_GHSR), m_gh);

            if (ug)                 m_gh = ((32'(grest) << 1) | 32'(ut)) % 256;
            else if (fv && exp_hit) m_gh = ((m_gh << 1) | 32'(exp_tk)) % 256;
            if (uv && !uj) begin
                ti = ((upc >> 2) % 256) ^ (HASH ? 32'(ughsr) : 0);
                if (ut) m_pht[ti] = (m_pht[ti] == 3) ? 3 : m_pht[ti] + 1;
                else    m_pht[ti] = (m_pht[ti] == 0) ? 0 : m_pht[ti] - 1;
            end
            if (uv && ut) begin
                bi = (upc >> 2) % 16;
                m_bv[bi] = 1; m_btag[bi] = upc >> 6; m_btgt[bi] = utgt; m_bj[bi] = uj;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
